// File: rtl/join_stage_pkg.sv
// Shared constants for the join pipeline stage.
// Selects how the two input words are combined.
package join_stage_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_XOR = 2;

endpackage

// File: rtl/join_stage_if.sv
// Handshake bundle for join_stage: two valid/stall producers and one valid/stall consumer.
interface join_stage_if #(
  parameter int WIDTH = 32
);

  logic             v_i1;
  logic [WIDTH-1:0] data_i1;
  logic             stall_o1;
  logic             v_i2;
  logic [WIDTH-1:0] data_i2;
  logic             stall_o2;
  logic             v_o;
  logic [WIDTH-1:0] data_o;
  logic             stall_i;

  modport master (
    output v_i1, data_i1, v_i2, data_i2, stall_i,
    input  stall_o1, stall_o2, v_o, data_o
  );

  modport slave (
    input  v_i1, data_i1, v_i2, data_i2, stall_i,
    output stall_o1, stall_o2, v_o, data_o
  );

endinterface

// File: rtl/join_stage_fifo.sv
// Per-input buffer for join_stage: DEPTH-entry circular FIFO with registered occupancy.
module join_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // One extra count bit keeps full (DEPTH) distinct from empty (0).
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/join_stage.sv
// Joins two buffered streams pairwise in order and emits OP(in1, in2) through a stallable output register.
module join_stage
  import join_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int OP    = OP_ADD
) (
  input logic         clk,
  input logic         reset,
  join_stage_if.slave bus
);

  logic [WIDTH-1:0] head1, head2;
  logic             full1, full2;
  logic             empty1, empty2;
  logic             push1, push2;
  logic             out_free;
  logic             fire;
  logic [WIDTH-1:0] result;
  logic             v_q;
  logic [WIDTH-1:0] data_q;

  // Backpressure comes only from registered occupancy, never from stall_i.
  assign push1    = bus.v_i1 & ~full1;
  assign push2    = bus.v_i2 & ~full2;
  assign out_free = ~v_q | ~bus.stall_i;
  assign fire     = ~empty1 & ~empty2 & out_free;

  join_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .reset (reset),
    .push  (push1),
    .pop   (fire),
    .din   (bus.data_i1),
    .head  (head1),
    .full  (full1),
    .empty (empty1)
  );

  join_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
    .clk   (clk),
    .reset (reset),
    .push  (push2),
    .pop   (fire),
    .din   (bus.data_i2),
    .head  (head2),
    .full  (full2),
    .empty (empty2)
  );

  always_comb begin
    case (OP)
      OP_SUB:  result = head1 - head2;
      OP_XOR:  result = head1 ^ head2;
      default: result = head1 + head2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else if (fire) begin
      v_q    <= 1'b1;
      data_q <= result;
    end else if (out_free) begin
      v_q    <= 1'b0;
    end
  end

  assign bus.v_o      = v_q;
  assign bus.data_o   = data_q;
  assign bus.stall_o1 = full1;
  assign bus.stall_o2 = full2;

endmodule

// File: tb/tb_join_stage.sv
// Self-checking bench for join_stage: directed vector table, stall/reset sequences and a random run vs a queue model.
module tb_join_stage;
  import join_stage_pkg::*;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        t_v1, t_v2, t_st;
  logic [31:0] t_d1, t_d2;

  join_stage_if #(.WIDTH(32)) if0 ();
  join_stage_if #(.WIDTH(32)) if1 ();
  join_stage_if #(.WIDTH(32)) if2 ();

  assign if0.v_i1 = t_v1;  assign if0.data_i1 = t_d1;
  assign if0.v_i2 = t_v2;  assign if0.data_i2 = t_d2;  assign if0.stall_i = t_st;
  assign if1.v_i1 = t_v1;  assign if1.data_i1 = t_d1;
  assign if1.v_i2 = t_v2;  assign if1.data_i2 = t_d2;  assign if1.stall_i = t_st;
  assign if2.v_i1 = t_v1;  assign if2.data_i1 = t_d1;
  assign if2.v_i2 = t_v2;  assign if2.data_i2 = t_d2;  assign if2.stall_i = t_st;

  join_stage #(.WIDTH(32), .DEPTH(DEPTH), .OP(OP_ADD)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  join_stage #(.WIDTH(32), .DEPTH(DEPTH), .OP(OP_SUB)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  join_stage #(.WIDTH(32), .DEPTH(DEPTH), .OP(OP_XOR)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference: accepted words wait in queues; the output register is one slot.
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic        m_v;
  logic [31:0] m_d0, m_d1, m_d2;
  bit          acc1, acc2;

  typedef struct {
    logic        v1;
    logic [31:0] d1;
    logic        v2;
    logic [31:0] d2;
    logic        st;
    logic        rs;
    logic        ev;
    logic [31:0] e0, e1, e2;
    logic        es1, es2;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic v1, input logic [31:0] d1, input logic v2, input logic [31:0] d2,
                      input logic st, input logic rs, input bit cm);
    bit free, fire, p1, p2;
    logic [31:0] h1, h2;
    t_v1 = v1; t_d1 = d1; t_v2 = v2; t_d2 = d2; t_st = st; reset = rs;
    free = !m_v || !st;
    fire = !rs && q1.size() > 0 && q2.size() > 0 && free;
    p1   = !rs && v1 && q1.size() < DEPTH;
    p2   = !rs && v2 && q2.size() < DEPTH;
    @(posedge clk);
    if (rs) begin
      q1.delete(); q2.delete();
      m_v = 1'b0; m_d0 = '0; m_d1 = '0; m_d2 = '0;
    end else begin
      if (fire) begin
        h1 = q1.pop_front();
        h2 = q2.pop_front();
        m_d0 = h1 + h2; m_d1 = h1 - h2; m_d2 = h1 ^ h2;
        m_v = 1'b1;
      end else if (free) begin
        m_v = 1'b0;
      end
      if (p1) q1.push_back(d1);
      if (p2) q2.push_back(d2);
    end
    acc1 = p1; acc2 = p2;
    #1;
    if (cm) begin
      chk("model_v_o",     {31'b0, if0.v_o},      {31'b0, m_v});
      chk("model_add",     if0.data_o,            m_d0);
      chk("model_sub",     if1.data_o,            m_d1);
      chk("model_xor",     if2.data_o,            m_d2);
      chk("model_stall1",  {31'b0, if0.stall_o1}, {31'b0, q1.size() == DEPTH});
      chk("model_stall2",  {31'b0, if0.stall_o2}, {31'b0, q2.size() == DEPTH});
    end
  endtask

  initial begin
    logic [31:0] held, w1, w2;
    t_v1 = 0; t_v2 = 0; t_d1 = 0; t_d2 = 0; t_st = 0; reset = 1;
    m_v = 0; m_d0 = 0; m_d1 = 0; m_d2 = 0;

    //           v1 d1           v2 d2  st rs  ev e0           e1           e2           s1 s2
    tbl[0]  = '{1, 5,           1, 7,  0, 0,  0, 0,           0,           0,           0, 0};
    tbl[1]  = '{0, 0,           0, 0,  0, 0,  1, 12,          32'hFFFFFFFE, 2,          0, 0};
    tbl[2]  = '{0, 0,           0, 0,  0, 0,  0, 12,          32'hFFFFFFFE, 2,          0, 0};
    tbl[3]  = '{1, 1,           1, 2,  0, 0,  0, 12,          32'hFFFFFFFE, 2,          0, 0};
    tbl[4]  = '{0, 0,           0, 0,  0, 0,  1, 3,           32'hFFFFFFFF, 3,          0, 0};
    tbl[5]  = '{1, 32'hFFFFFFFF, 1, 1, 0, 0,  0, 3,           32'hFFFFFFFF, 3,          0, 0};
    tbl[6]  = '{0, 0,           0, 0,  0, 0,  1, 0,           32'hFFFFFFFE, 32'hFFFFFFFE, 0, 0};
    tbl[7]  = '{0, 0,           0, 0,  0, 0,  0, 0,           32'hFFFFFFFE, 32'hFFFFFFFE, 0, 0};
    tbl[8]  = '{1, 10,          0, 0,  0, 0,  0, 0,           32'hFFFFFFFE, 32'hFFFFFFFE, 0, 0};
    tbl[9]  = '{1, 20,          0, 0,  0, 0,  0, 0,           32'hFFFFFFFE, 32'hFFFFFFFE, 1, 0};
    tbl[10] = '{1, 30,          0, 0,  0, 0,  0, 0,           32'hFFFFFFFE, 32'hFFFFFFFE, 1, 0};
    tbl[11] = '{1, 30,          1, 1,  0, 0,  0, 0,           32'hFFFFFFFE, 32'hFFFFFFFE, 1, 0};
    tbl[12] = '{1, 30,          1, 2,  0, 0,  1, 11,          9,           11,          0, 0};
    tbl[13] = '{1, 30,          0, 0,  0, 0,  1, 22,          18,          22,          0, 0};
    tbl[14] = '{0, 0,           0, 0,  0, 0,  0, 22,          18,          22,          0, 0};
    tbl[15] = '{1, 9,           1, 9,  0, 1,  0, 0,           0,           0,           0, 0};

    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("reset_v_o",    {31'b0, if0.v_o},      32'd0);
    chk("reset_data_o", if0.data_o,            32'd0);
    chk("reset_stall1", {31'b0, if0.stall_o1}, 32'd0);
    chk("reset_stall2", {31'b0, if0.stall_o2}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].v1, tbl[i].d1, tbl[i].v2, tbl[i].d2, tbl[i].st, tbl[i].rs, 0);
      chk($sformatf("vec%0d_v_o", i),    {31'b0, if0.v_o},      {31'b0, tbl[i].ev});
      chk($sformatf("vec%0d_add", i),    if0.data_o,            tbl[i].e0);
      chk($sformatf("vec%0d_sub", i),    if1.data_o,            tbl[i].e1);
      chk($sformatf("vec%0d_xor", i),    if2.data_o,            tbl[i].e2);
      chk($sformatf("vec%0d_stall1", i), {31'b0, if0.stall_o1}, {31'b0, tbl[i].es1});
      chk($sformatf("vec%0d_stall2", i), {31'b0, if0.stall_o2}, {31'b0, tbl[i].es2});
    end

    // Streaming producers hold their word until it is accepted.
    w1 = 32'h100; w2 = 32'h200;
    for (int i = 0; i < 4; i++) begin
      step(1, w1, 1, w2, 0, 0, 1);
      if (acc1) w1++;
      if (acc2) w2++;
    end
    held = if0.data_o;
    for (int i = 0; i < 4; i++) begin
      step(1, w1, 1, w2, 1, 0, 1);
      if (acc1) w1++;
      if (acc2) w2++;
      chk("stall_hold_data", if0.data_o, held);
      chk("stall_hold_v",    {31'b0, if0.v_o}, 32'd1);
    end
    chk("stall_full1", {31'b0, if0.stall_o1}, 32'd1);
    chk("stall_full2", {31'b0, if0.stall_o2}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      step(1, w1, 1, w2, 0, 0, 1);
      if (acc1) w1++;
      if (acc2) w2++;
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 2) == 0), 0, 1);
    end

    for (int i = 0; i < 6; i++) step(1, $urandom, 1, $urandom, 1, 0, 1);
    chk("pre_reset_v_o",    {31'b0, if0.v_o},      32'd1);
    chk("pre_reset_stall1", {31'b0, if0.stall_o1}, 32'd1);
    chk("pre_reset_stall2", {31'b0, if0.stall_o2}, 32'd1);
    step(1, 32'h55, 1, 32'h66, 0, 1, 1);
    chk("mid_reset_v_o",    {31'b0, if0.v_o},      32'd0);
    chk("mid_reset_data_o", if0.data_o,            32'd0);
    chk("mid_reset_stall1", {31'b0, if0.stall_o1}, 32'd0);
    chk("mid_reset_stall2", {31'b0, if0.stall_o2}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 1);
      chk("no_stale_v_o", {31'b0, if0.v_o}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/join_stage.md
JOIN_STAGE -- requirements
Module: join_stage

Interface
REQ-001 Parameter WIDTH, default 32, data width of both inputs and the output.
REQ-002 Parameter DEPTH, default 2, entries per input buffer; power of two, at least 2.
REQ-003 Parameter OP, default 0, combine operation: 0 add, 1 subtract (in1 - in2), 2 bitwise xor.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port v_i1  input  1  input 1 data valid.
REQ-007 Port data_i1  input  WIDTH  input 1 data.
REQ-008 Port stall_o1  output  1  backpressure to the input 1 producer.
REQ-009 Port v_i2  input  1  input 2 data valid.
REQ-010 Port data_i2  input  WIDTH  input 2 data.
REQ-011 Port stall_o2  output  1  backpressure to the input 2 producer.
REQ-012 Port v_o  output  1  output valid.
REQ-013 Port data_o  output  WIDTH  combined result.
REQ-014 Port stall_i  input  1  backpressure from the downstream consumer.

Function
REQ-015 Each input N SHALL own a FIFO of DEPTH entries; a push on N occurs on a cycle with v_iN=1 and stall_oN=0.
REQ-016 stall_oN SHALL equal "FIFO N full", driven from registered count only, never combinationally from stall_i or v_iN.
REQ-017 A word offered while stall_oN=1 SHALL NOT be captured; the producer holds it.
REQ-018 The output register (v_o, data_o) SHALL be free when v_o=0 or stall_i=0.
REQ-019 Fire SHALL occur when both FIFOs are non-empty and the output register is free.
REQ-020 On fire: pop both heads, data_o <= OP(head1, head2) truncated to WIDTH bits (mod 2^WIDTH), v_o <= 1.
REQ-021 When the output register is free and no fire occurs, v_o SHALL go to 0; data_o holds its last value.
REQ-022 While v_o=1 and stall_i=1, v_o and data_o SHALL hold unchanged.
REQ-023 Pairing SHALL be strictly in order: the k-th accepted word of input 1 combines with the k-th of input 2.
REQ-024 Latency: with both words pushed at edge t into empty FIFOs and no stall, v_o=1 SHALL appear after edge t+1.
REQ-025 Throughput: with both inputs streaming and stall_i=0, one result per cycle sustained.
REQ-026 Push and pop on the same FIFO in the same cycle SHALL leave its count unchanged and remain legal when non-empty.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; the count ranges 0..DEPTH without aliasing full and empty.
REQ-028 A one-sided arrival SHALL wait in its FIFO indefinitely; the other input is never stalled because of it.

Reset
REQ-029 reset=1 at a rising edge SHALL clear both FIFO counts and pointers, v_o=0, data_o=0.
REQ-030 After reset, stall_o1=0 and stall_o2=0; reset asserted mid-operation discards all buffered and output data.
REQ-031 No push or fire SHALL take effect on an edge where reset=1.

Structure
REQ-032 The OP encodings (ADD, SUB, XOR) SHALL be constants in the shared pipeline package.
REQ-033 The per-input buffer SHALL be one sub-module, join_fifo (WIDTH, DEPTH; push, pop, head, full, empty), instantiated twice.

Verification
REQ-034 Simultaneous push of 5 and 7, OP=0, stall_i=0 -> v_o=1, data_o=12 two edges after the push, one cycle only.
REQ-035 Input 1 pushes 3 words while input 2 stays idle -> stall_o1=1 after 2 pushes, stall_o2=0; input 2 then sends 1,2 -> results appear in order.
REQ-036 OP=1: 0x00000001 - 0x00000002 -> data_o=0xFFFFFFFF; OP=0: 0xFFFFFFFF + 1 -> data_o=0.
REQ-037 stall_i held high for 4 cycles with both inputs streaming -> data_o stable, both stall_oN=1 once the FIFOs fill, no loss or duplication after release.
REQ-038 Random valid on both inputs and random stall_i over 1000 cycles -> output sequence equals the in-order pairwise OP of the accepted words.
REQ-039 reset pulsed with both FIFOs full and v_o=1 -> next cycle v_o=0, data_o=0, both stall_oN=0, and no stale word is ever emitted.
